// File: rtl/stlb_lookup_sequencer.sv
// stlb_lookup_sequencer: serves L1 TLB misses from several requesters through a shared
// second-level TLB. Requesters are picked round-robin. The picked request is looked up
// in the shared TLB. On a TLB miss a page-table walk is started, the walk result is
// written back into the TLB, and the translation is returned to the granted requester.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   flush_i                      SFENCE flush, aborts the sequence in flight
//   req_valid/vaddr/asid_i       per-requester miss requests (slice i = requester i)
//   req_gnt_o                    one-hot grant pulse (combinational, IDLE only)
//   rsp_valid_o, rsp_*_o         one-hot response pulse plus registered translation
//   lu_*                         shared TLB lookup port
//   walk_*                       page-table walker request/return
//   upd_*                        shared TLB update port
// Optional build macro STLB_SEQ_PERF_EN adds saturating hit/miss/fault counters.

module stlb_lookup_sequencer #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned VLEN       = 39,
    parameter int unsigned ASID_WIDTH = 1,
    parameter int unsigned PTE_WIDTH  = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*VLEN-1:0]       req_vaddr_i,
    input  logic [NUM_REQ*ASID_WIDTH-1:0] req_asid_i,
    output logic [NUM_REQ-1:0]            req_gnt_o,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic                          rsp_err_o,
    output logic [PTE_WIDTH-1:0]          rsp_content_o,
    output logic                          rsp_is_2M_o,
    output logic                          rsp_is_1G_o,
    output logic                          lu_access_o,
    output logic [VLEN-1:0]               lu_vaddr_o,
    output logic [ASID_WIDTH-1:0]         lu_asid_o,
    input  logic                          lu_hit_i,
    input  logic [PTE_WIDTH-1:0]          lu_content_i,
    input  logic                          lu_is_2M_i,
    input  logic                          lu_is_1G_i,
    output logic                          walk_req_o,
    output logic [VLEN-1:0]               walk_vaddr_o,
    output logic [ASID_WIDTH-1:0]         walk_asid_o,
    input  logic                          walk_valid_i,
    input  logic                          walk_err_i,
    input  logic [PTE_WIDTH-1:0]          walk_pte_i,
    input  logic                          walk_is_2M_i,
    input  logic                          walk_is_1G_i,
    output logic                          upd_valid_o,
    output logic [26:0]                   upd_vpn_o,
    output logic [ASID_WIDTH-1:0]         upd_asid_o,
    output logic [PTE_WIDTH-1:0]          upd_content_o,
    output logic                          upd_is_2M_o,
    output logic                          upd_is_1G_o
`ifdef STLB_SEQ_PERF_EN
    ,
    output logic [31:0]                   perf_hit_cnt_o,
    output logic [31:0]                   perf_miss_cnt_o,
    output logic [31:0]                   perf_fault_cnt_o
`endif
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned VPN_W  = 27;
    localparam int unsigned PG_OFF = 12;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WALK, S_UPDATE, S_RESP, S_DRAIN
    } state_e;

    state_e                  r_state, w_next;
    logic [IDX_W-1:0]        r_rr_ptr, r_idx;
    logic [VLEN-1:0]         r_vaddr;
    logic [ASID_WIDTH-1:0]   r_asid;
    logic [PTE_WIDTH-1:0]    r_content;
    logic                    r_is_2M, r_is_1G, r_err;

    logic                    w_gnt_any, w_grant;
    logic [IDX_W-1:0]        w_gnt_idx;
    logic [VLEN-1:0]         w_sel_vaddr;
    logic [ASID_WIDTH-1:0]   w_sel_asid;

    // Round-robin pick: first valid index at or after the pointer, then wrap below it.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!w_gnt_any && req_valid_i[i] && (i >= int'(r_rr_ptr))) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (!w_gnt_any && req_valid_i[i] && (i < int'(r_rr_ptr))) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = IDX_W'(i);
            end
        end
    end

    // Payload mux for the picked requester.
    always_comb begin
        w_sel_vaddr = '0;
        w_sel_asid  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (i == int'(w_gnt_idx)) begin
                w_sel_vaddr = req_vaddr_i[i*VLEN +: VLEN];
                w_sel_asid  = req_asid_i[i*ASID_WIDTH +: ASID_WIDTH];
            end
        end
    end

    // rst_i gate keeps the grant low while reset is held.
    assign w_grant = (r_state == S_IDLE) && w_gnt_any && !flush_i && !rst_i;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next state and strobes.
    always_comb begin
        w_next      = r_state;
        req_gnt_o   = '0;
        rsp_valid_o = '0;
        lu_access_o = 1'b0;
        walk_req_o  = 1'b0;
        upd_valid_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    req_gnt_o = NUM_REQ'(1) << w_gnt_idx;
                    w_next    = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                lu_access_o = 1'b1;
                if (flush_i)       w_next = S_IDLE;
                else if (lu_hit_i) w_next = S_RESP;
                else               w_next = S_WALK;
            end
            S_WALK: begin
                walk_req_o = 1'b1;
                // A walk finishing in the flush cycle is simply discarded.
                if (walk_valid_i) begin
                    if (flush_i)         w_next = S_IDLE;
                    else if (walk_err_i) w_next = S_RESP;
                    else                 w_next = S_UPDATE;
                end else if (flush_i) begin
                    w_next = S_DRAIN;
                end
            end
            S_UPDATE: begin
                upd_valid_o = !flush_i;
                w_next      = flush_i ? S_IDLE : S_RESP;
            end
            S_RESP: begin
                if (!flush_i) rsp_valid_o = NUM_REQ'(1) << r_idx;
                w_next = S_IDLE;
            end
            S_DRAIN: begin
                if (walk_valid_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Capture request on grant, translation on lookup hit or walk return.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr_ptr  <= '0;
            r_idx     <= '0;
            r_vaddr   <= '0;
            r_asid    <= '0;
            r_content <= '0;
            r_is_2M   <= 1'b0;
            r_is_1G   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if (w_grant) begin
                r_idx    <= w_gnt_idx;
                r_vaddr  <= w_sel_vaddr;
                r_asid   <= w_sel_asid;
                r_err    <= 1'b0;
                r_rr_ptr <= (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + IDX_W'(1);
            end
            if (r_state == S_LOOKUP && lu_hit_i) begin
                r_content <= lu_content_i;
                r_is_2M   <= lu_is_2M_i;
                r_is_1G   <= lu_is_1G_i;
            end
            if (r_state == S_WALK && walk_valid_i) begin
                r_content <= walk_err_i ? '0 : walk_pte_i;
                r_is_2M   <= walk_is_2M_i && !walk_err_i;
                r_is_1G   <= walk_is_1G_i && !walk_err_i;
                r_err     <= walk_err_i;
            end
        end
    end

    assign lu_vaddr_o    = r_vaddr;
    assign lu_asid_o     = r_asid;
    assign walk_vaddr_o  = r_vaddr;
    assign walk_asid_o   = r_asid;
    assign upd_vpn_o     = r_vaddr[PG_OFF +: VPN_W];
    assign upd_asid_o    = r_asid;
    assign upd_content_o = r_content;
    assign upd_is_2M_o   = r_is_2M;
    assign upd_is_1G_o   = r_is_1G;
    assign rsp_content_o = r_content;
    assign rsp_is_2M_o   = r_is_2M;
    assign rsp_is_1G_o   = r_is_1G;
    assign rsp_err_o     = r_err;

`ifdef STLB_SEQ_PERF_EN
    logic [31:0] r_hit_cnt, r_miss_cnt, r_fault_cnt;

    // Saturating event counters; only reset clears them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
            r_fault_cnt <= '0;
        end else begin
            if (r_state == S_LOOKUP && lu_hit_i && r_hit_cnt != '1)
                r_hit_cnt <= r_hit_cnt + 32'd1;
            if (r_state == S_LOOKUP && !lu_hit_i && r_miss_cnt != '1)
                r_miss_cnt <= r_miss_cnt + 32'd1;
            if (r_state == S_WALK && walk_valid_i && walk_err_i && r_fault_cnt != '1)
                r_fault_cnt <= r_fault_cnt + 32'd1;
        end
    end

    assign perf_hit_cnt_o   = r_hit_cnt;
    assign perf_miss_cnt_o  = r_miss_cnt;
    assign perf_fault_cnt_o = r_fault_cnt;
`endif

endmodule

// File: tb/tb_stlb_lookup_sequencer.sv
// Directed testbench for stlb_lookup_sequencer (default build, NUM_REQ = 2).
module tb_stlb_lookup_sequencer;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         flush_i = 1'b0;
    logic [1:0]   req_valid_i = '0;
    logic [77:0]  req_vaddr_i = '0;
    logic [1:0]   req_asid_i = '0;
    logic [1:0]   req_gnt_o, rsp_valid_o;
    logic         rsp_err_o, rsp_is_2M_o, rsp_is_1G_o;
    logic [63:0]  rsp_content_o;
    logic         lu_access_o;
    logic [38:0]  lu_vaddr_o;
    logic [0:0]   lu_asid_o;
    logic         lu_hit_i = 1'b0, lu_is_2M_i = 1'b0, lu_is_1G_i = 1'b0;
    logic [63:0]  lu_content_i = '0;
    logic         walk_req_o;
    logic [38:0]  walk_vaddr_o;
    logic [0:0]   walk_asid_o;
    logic         walk_valid_i = 1'b0, walk_err_i = 1'b0;
    logic [63:0]  walk_pte_i = '0;
    logic         walk_is_2M_i = 1'b0, walk_is_1G_i = 1'b0;
    logic         upd_valid_o, upd_is_2M_o, upd_is_1G_o;
    logic [26:0]  upd_vpn_o;
    logic [0:0]   upd_asid_o;
    logic [63:0]  upd_content_o;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk_i = ~clk_i;

    stlb_lookup_sequencer dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .req_valid_i(req_valid_i), .req_vaddr_i(req_vaddr_i), .req_asid_i(req_asid_i),
        .req_gnt_o(req_gnt_o), .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o),
        .rsp_content_o(rsp_content_o), .rsp_is_2M_o(rsp_is_2M_o), .rsp_is_1G_o(rsp_is_1G_o),
        .lu_access_o(lu_access_o), .lu_vaddr_o(lu_vaddr_o), .lu_asid_o(lu_asid_o),
        .lu_hit_i(lu_hit_i), .lu_content_i(lu_content_i),
        .lu_is_2M_i(lu_is_2M_i), .lu_is_1G_i(lu_is_1G_i),
        .walk_req_o(walk_req_o), .walk_vaddr_o(walk_vaddr_o), .walk_asid_o(walk_asid_o),
        .walk_valid_i(walk_valid_i), .walk_err_i(walk_err_i), .walk_pte_i(walk_pte_i),
        .walk_is_2M_i(walk_is_2M_i), .walk_is_1G_i(walk_is_1G_i),
        .upd_valid_o(upd_valid_o), .upd_vpn_o(upd_vpn_o), .upd_asid_o(upd_asid_o),
        .upd_content_o(upd_content_o), .upd_is_2M_o(upd_is_2M_o), .upd_is_1G_o(upd_is_1G_o)
    );

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk_i);
        #2;
        n_total++; if ({req_gnt_o, rsp_valid_o, lu_access_o, walk_req_o, upd_valid_o, rsp_err_o} !== 8'h00)
            $display("FAIL reset_strobes: got %b exp 00000000", {req_gnt_o, rsp_valid_o, lu_access_o, walk_req_o, upd_valid_o, rsp_err_o}); else n_pass++;
        n_total++; if ({rsp_content_o, lu_vaddr_o, upd_vpn_o} !== 130'h0)
            $display("FAIL reset_data: got %h exp 0", {rsp_content_o, lu_vaddr_o, upd_vpn_o}); else n_pass++;
        nxt();
        rst_i = 1'b0;
    endtask

    task automatic test_hit();
        req_valid_i = 2'b01; req_vaddr_i[0 +: 39] = 39'h12345000; req_asid_i[0] = 1'b1;
        lu_hit_i = 1'b1; lu_content_i = 64'hAB;
        #1;
        n_total++; if (req_gnt_o !== 2'b01) $display("FAIL hit_gnt: got %b exp 01", req_gnt_o); else n_pass++;
        nxt(); #1;
        n_total++; if ({lu_access_o, req_gnt_o} !== 3'b100) $display("FAIL hit_lu_access: got %b exp 100", {lu_access_o, req_gnt_o}); else n_pass++;
        n_total++; if ({lu_vaddr_o, lu_asid_o} !== {39'h12345000, 1'b1}) $display("FAIL hit_lu_addr: got %h/%b exp 12345000/1", lu_vaddr_o, lu_asid_o); else n_pass++;
        nxt(); #1;
        n_total++; if (rsp_valid_o !== 2'b01) $display("FAIL hit_rsp_valid: got %b exp 01", rsp_valid_o); else n_pass++;
        n_total++; if ({rsp_content_o, rsp_err_o} !== {64'hAB, 1'b0}) $display("FAIL hit_rsp_data: got %h err %b exp ab err 0", rsp_content_o, rsp_err_o); else n_pass++;
        n_total++; if (lu_access_o !== 1'b0) $display("FAIL hit_lu_one_cycle: got %b exp 0", lu_access_o); else n_pass++;
        req_valid_i = 2'b00;
        nxt();
    endtask

    task automatic test_miss();
        req_valid_i = 2'b10; req_vaddr_i[39 +: 39] = 39'h12_3456_7000; req_asid_i[1] = 1'b0;
        lu_hit_i = 1'b0;
        #1;
        n_total++; if (req_gnt_o !== 2'b10) $display("FAIL miss_gnt: got %b exp 10", req_gnt_o); else n_pass++;
        nxt(); nxt();
        for (int k = 0; k < 5; k++) begin
            #1;
            n_total++; if ({walk_req_o, upd_valid_o, rsp_valid_o} !== 4'b1000)
                $display("FAIL miss_walk_wait%0d: got %b exp 1000", k, {walk_req_o, upd_valid_o, rsp_valid_o}); else n_pass++;
            nxt();
        end
        walk_valid_i = 1'b1; walk_pte_i = 64'hCD; walk_is_2M_i = 1'b1;
        nxt();
        walk_valid_i = 1'b0; walk_pte_i = '0; walk_is_2M_i = 1'b0;
        #1;
        n_total++; if ({upd_valid_o, walk_req_o, rsp_valid_o} !== 4'b1000) $display("FAIL miss_upd_strobe: got %b exp 1000", {upd_valid_o, walk_req_o, rsp_valid_o}); else n_pass++;
        n_total++; if ({upd_vpn_o, upd_content_o, upd_is_2M_o, upd_is_1G_o} !== {27'h1234567, 64'hCD, 2'b10})
            $display("FAIL miss_upd_data: got vpn %h pte %h 2M %b 1G %b exp 1234567 cd 1 0", upd_vpn_o, upd_content_o, upd_is_2M_o, upd_is_1G_o); else n_pass++;
        nxt(); #1;
        n_total++; if ({rsp_valid_o, upd_valid_o} !== 3'b100) $display("FAIL miss_rsp_valid: got %b exp 100", {rsp_valid_o, upd_valid_o}); else n_pass++;
        n_total++; if ({rsp_content_o, rsp_is_2M_o, rsp_err_o} !== {64'hCD, 2'b10}) $display("FAIL miss_rsp_data: got %h 2M %b err %b exp cd 1 0", rsp_content_o, rsp_is_2M_o, rsp_err_o); else n_pass++;
        req_valid_i = 2'b00;
        nxt();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g;
        req_valid_i = 2'b11; lu_hit_i = 1'b1; lu_content_i = 64'h11;
        for (int s = 0; s < 4; s++) begin
            exp_g = (s % 2 == 1) ? 2'b10 : 2'b01;
            #1;
            n_total++; if (req_gnt_o !== exp_g) $display("FAIL rr_gnt%0d: got %b exp %b", s, req_gnt_o, exp_g); else n_pass++;
            nxt(); nxt(); #1;
            n_total++; if (rsp_valid_o !== exp_g) $display("FAIL rr_rsp%0d: got %b exp %b", s, rsp_valid_o, exp_g); else n_pass++;
            nxt();
        end
        req_valid_i = 2'b00;
        nxt();
    endtask

    task automatic test_fault();
        req_valid_i = 2'b01; lu_hit_i = 1'b0;
        nxt(); nxt();
        walk_valid_i = 1'b1; walk_err_i = 1'b1; walk_pte_i = 64'hEE; walk_is_1G_i = 1'b1;
        #1;
        n_total++; if (walk_req_o !== 1'b1) $display("FAIL fault_walk_req: got %b exp 1", walk_req_o); else n_pass++;
        nxt();
        walk_valid_i = 1'b0; walk_err_i = 1'b0; walk_pte_i = '0; walk_is_1G_i = 1'b0;
        #1;
        n_total++; if ({rsp_valid_o, upd_valid_o, rsp_err_o} !== 4'b0101) $display("FAIL fault_rsp: got %b exp 0101", {rsp_valid_o, upd_valid_o, rsp_err_o}); else n_pass++;
        n_total++; if ({rsp_content_o, rsp_is_1G_o} !== 65'h0) $display("FAIL fault_rsp_data: got %h 1G %b exp 0 0", rsp_content_o, rsp_is_1G_o); else n_pass++;
        req_valid_i = 2'b00;
        nxt();
    endtask

    task automatic test_flush_walk();
        req_valid_i = 2'b10; lu_hit_i = 1'b0;
        #1;
        n_total++; if (req_gnt_o !== 2'b10) $display("FAIL flush_gnt: got %b exp 10", req_gnt_o); else n_pass++;
        nxt(); nxt();
        flush_i = 1'b1; req_valid_i = 2'b00;
        #1;
        n_total++; if (walk_req_o !== 1'b1) $display("FAIL flush_walk_req_before: got %b exp 1", walk_req_o); else n_pass++;
        nxt();
        flush_i = 1'b0; req_valid_i = 2'b01; lu_hit_i = 1'b1; lu_content_i = 64'h77;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_total++; if ({walk_req_o, req_gnt_o} !== 3'b000) $display("FAIL flush_drain%0d: got %b exp 000", k, {walk_req_o, req_gnt_o}); else n_pass++;
            nxt();
        end
        walk_valid_i = 1'b1; walk_pte_i = 64'h99;
        #1;
        n_total++; if ({req_gnt_o, upd_valid_o, rsp_valid_o} !== 5'b0) $display("FAIL flush_drain_ret: got %b exp 00000", {req_gnt_o, upd_valid_o, rsp_valid_o}); else n_pass++;
        nxt();
        walk_valid_i = 1'b0; walk_pte_i = '0;
        #1;
        n_total++; if ({req_gnt_o, upd_valid_o} !== 3'b010) $display("FAIL flush_regrant: got %b exp 010", {req_gnt_o, upd_valid_o}); else n_pass++;
        nxt(); nxt(); #1;
        n_total++; if ({rsp_valid_o, rsp_content_o} !== {2'b01, 64'h77}) $display("FAIL flush_after_rsp: got %b %h exp 01 77", rsp_valid_o, rsp_content_o); else n_pass++;
        req_valid_i = 2'b00;
        nxt();
    endtask

    task automatic test_reset_mid_update();
        req_valid_i = 2'b01; lu_hit_i = 1'b0;
        nxt(); nxt();
        walk_valid_i = 1'b1; walk_pte_i = 64'h55;
        nxt();
        walk_valid_i = 1'b0; walk_pte_i = '0;
        #1;
        n_total++; if (upd_valid_o !== 1'b1) $display("FAIL rst_pre_upd: got %b exp 1", upd_valid_o); else n_pass++;
        rst_i = 1'b1;
        #1;
        n_total++; if ({req_gnt_o, rsp_valid_o, lu_access_o, walk_req_o, upd_valid_o} !== 7'b0)
            $display("FAIL rst_async_zero: got %b exp 0000000", {req_gnt_o, rsp_valid_o, lu_access_o, walk_req_o, upd_valid_o}); else n_pass++;
        n_total++; if (upd_content_o !== 64'h0) $display("FAIL rst_async_data: got %h exp 0", upd_content_o); else n_pass++;
        nxt();
        rst_i = 1'b0; req_valid_i = 2'b11;
        #1;
        n_total++; if (req_gnt_o !== 2'b01) $display("FAIL rst_regrant_idx0: got %b exp 01", req_gnt_o); else n_pass++;
        req_valid_i = 2'b00;
        nxt();
    endtask

    initial begin
        test_reset();
        test_hit();
        test_miss();
        test_round_robin();
        test_fault();
        test_flush_walk();
        test_reset_mid_update();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
